// File: rtl/mux2_rr_arbiter.sv
// Round-robin owner of a shared 2:1 mux on the Tiny Tapeout pin frame.
// The grant lasts quantum+1 cycles, can be held by lock, and selects which data bit drives y.
module mux2_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  logic [2:0] cnt_reg, cnt_next;
  logic       sel_reg, sel_next;
  logic       take_a, take_b;

  logic       req_a, req_b, data_a, data_b, lock;
  logic [2:0] quantum;
  logic       gnt_a, gnt_b, y, expire;
  logic       unused_pins;

  assign req_a   = ui_in[0];
  assign req_b   = ui_in[1];
  assign data_a  = ui_in[2];
  assign data_b  = ui_in[3];
  assign lock    = ui_in[4];
  assign quantum = ui_in[7:5];

  assign unused_pins = &{1'b0, uio_in, ena};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 3'd0;
      sel_reg   <= 1'b1;  // B counts as last served, so A wins the first tie
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      sel_reg   <= sel_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    sel_next   = sel_reg;
    take_a     = 1'b0;
    take_b     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_a && (!req_b || sel_reg)) take_a = 1'b1;
        else if (req_b)                   take_b = 1'b1;
      end
      GNT_A: begin
        if (!req_a) begin
          if (req_b) take_b = 1'b1;
          else begin
            state_next = IDLE;
            cnt_next   = 3'd0;
          end
        end else if (cnt_reg != 3'd0) begin
          cnt_next = cnt_reg - 3'd1;
        end else if (!lock) begin
          if (req_b) take_b = 1'b1;
          else       take_a = 1'b1;
        end
      end
      GNT_B: begin
        if (!req_b) begin
          if (req_a) take_a = 1'b1;
          else begin
            state_next = IDLE;
            cnt_next   = 3'd0;
          end
        end else if (cnt_reg != 3'd0) begin
          cnt_next = cnt_reg - 3'd1;
        end else if (!lock) begin
          if (req_a) take_a = 1'b1;
          else       take_b = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 3'd0;
      end
    endcase
    // Entry and renewal share one path so quantum is only sampled here.
    if (take_a) begin
      state_next = GNT_A;
      cnt_next   = quantum;
      sel_next   = 1'b0;
    end
    if (take_b) begin
      state_next = GNT_B;
      cnt_next   = quantum;
      sel_next   = 1'b1;
    end
  end

  assign gnt_a  = (state_reg == GNT_A);
  assign gnt_b  = (state_reg == GNT_B);
  assign y      = (gnt_a & data_a) | (gnt_b & data_b);
  assign expire = (gnt_a | gnt_b) & (cnt_reg == 3'd0);

  assign uo_out  = {cnt_reg, expire, sel_reg, gnt_b, gnt_a, y};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed-vector bench for mux2_rr_arbiter; expected uo_out values are hand-packed as
// {cnt[2:0], expire, sel, gnt_b, gnt_a, y}.
module tb_mux2_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       ena;

  int checks;
  int failures;

  mux2_rr_arbiter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 8'h%02h expected 8'h%02h", tag, obs, exp);
    end else begin
      $display("ok   %s: 8'h%02h", tag, obs);
    end
  endtask

  // Drive ui_in, let one rising edge take it, then sample 1 time unit later.
  task automatic apply(input logic [7:0] ui, input logic [7:0] exp, input string tag);
    ui_in = ui;
    @(posedge clk);
    #1;
    check_val(tag, uo_out, exp);
  endtask

  task automatic do_reset(input logic [7:0] ui, input string tag);
    @(negedge clk);
    ui_in = ui;
    rst_n = 1'b0;
    #2;
    check_val({tag, "_uo"}, uo_out, 8'h08);
    check_val({tag, "_uio_out"}, uio_out, 8'h00);
    check_val({tag, "_uio_oe"}, uio_oe, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    ui_in = 8'h00;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    ui_in    = 8'hFF;
    uio_in   = 8'hA5;
    ena      = 1'b1;
    #3;

    // Reset with arbitrary inputs applied.
    do_reset(8'hFF, "reset");

    // Single requester, quantum=2: cnt 2,1,0,2,... and y follows data_a.
    apply(8'h45, 8'h43, "single_c1");
    apply(8'h45, 8'h23, "single_c2");
    apply(8'h45, 8'h13, "single_c3");
    apply(8'h45, 8'h43, "single_renew");
    apply(8'h41, 8'h22, "single_data0");
    ui_in = 8'h45;
    #1;
    check_val("single_y_comb", uo_out, 8'h23);
    apply(8'h45, 8'h13, "single_c0");
    apply(8'h45, 8'h43, "single_renew2");
    apply(8'h00, 8'h00, "single_release_lo");
    check_val("single_release_gnt", uo_out & 8'h1F, 8'h00);

    // Contention, quantum=3: A for 4, B for 4, then A, no gaps.
    do_reset(8'h67, "reset2");
    apply(8'h67, 8'h63, "cont_a3");
    apply(8'h67, 8'h43, "cont_a2");
    apply(8'h67, 8'h23, "cont_a1");
    apply(8'h67, 8'h13, "cont_a0");
    apply(8'h67, 8'h6C, "cont_b3");
    apply(8'h67, 8'h4C, "cont_b2");
    apply(8'h67, 8'h2C, "cont_b1");
    apply(8'h67, 8'h1C, "cont_b0");
    apply(8'h67, 8'h63, "cont_a3_again");
    // Reset asserted away from a clock edge clears outputs immediately.
    #2;
    rst_n = 1'b0;
    #1;
    check_val("midgrant_reset", uo_out, 8'h08);
    @(negedge clk);
    rst_n = 1'b1;

    // Early release: B owns, A waiting, B drops -> A granted with new quantum.
    do_reset(8'h00, "reset3");
    apply(8'hAA, 8'hAD, "early_b5");
    apply(8'hAB, 8'h8D, "early_b4");
    apply(8'h69, 8'h62, "early_release_a");

    // Lock with quantum=0: A holds with expire=1, then switch on lock drop.
    do_reset(8'h00, "reset4");
    apply(8'h17, 8'h13, "lock_grant");
    for (int i = 0; i < 9; i++) apply(8'h17, 8'h13, $sformatf("lock_hold%0d", i));
    apply(8'h07, 8'h1C, "lock_drop_b");
    apply(8'h07, 8'h13, "lock_drop_a");

    // Lock asserted while cnt != 0 does not freeze the count.
    do_reset(8'h00, "reset5");
    apply(8'h41, 8'h42, "early_lock_c2");
    apply(8'h51, 8'h22, "early_lock_c1");
    apply(8'h51, 8'h12, "early_lock_c0");
    apply(8'h51, 8'h12, "early_lock_hold");

    // Quantum change mid-grant keeps the current 8-cycle grant.
    do_reset(8'h00, "reset6");
    apply(8'hE1, 8'hE2, "qchg_c7");
    apply(8'hE1, 8'hC2, "qchg_c6");
    apply(8'h21, 8'hA2, "qchg_c5");
    apply(8'h21, 8'h82, "qchg_c4");
    apply(8'h21, 8'h62, "qchg_c3");
    apply(8'h21, 8'h42, "qchg_c2");
    apply(8'h21, 8'h22, "qchg_c1");
    apply(8'h21, 8'h12, "qchg_c0");
    apply(8'h21, 8'h22, "qchg_new1");
    apply(8'h21, 8'h12, "qchg_new0");
    apply(8'h21, 8'h22, "qchg_new1b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux2_rr_arbiter.md
# mux2_rr_arbiter

Round-robin arbiter that shares the 2:1 output mux between two requesters (A and B) on the Tiny Tapeout user-project pin frame. It grants the mux to one requester at a time for a runtime-programmable quantum of 1–8 cycles, drives the mux select from its grant state and presents the selected data bit on `uo_out[0]`. A lock input lets the current owner hold the mux past quantum expiry.

## Interface
- Parameters: none. The quantum is configured at runtime through `ui_in[7:5]`.
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ui_in` in 8:
  - [0] `req_a`, [1] `req_b`: request lines.
  - [2] `data_a`, [3] `data_b`: mux data inputs.
  - [4] `lock`: hold the current grant past quantum expiry.
  - [7:5] `quantum`: grant length, in cycles, minus 1.
- `uo_out` out 8:
  - [0] `y`: muxed data.
  - [1] `gnt_a`, [2] `gnt_b`: grant outputs.
  - [3] `sel`: last-served flag, 1 = B.
  - [4] `expire`: last cycle of the current quantum.
  - [7:5] `cnt`: remaining quantum cycles.
- `uio_in` in 8: unused.
- `uio_out` out 8: constant 0.
- `uio_oe` out 8: constant 0 (all uio pins are inputs).
- `ena` in 1: unused; always 1 when the design is powered.

## Operation
- **States:** IDLE, GNT_A, GNT_B. The grant outputs are registered and one-hot-or-zero: `gnt_a` = (state==GNT_A), `gnt_b` = (state==GNT_B).
- **Reset values:** state IDLE, `cnt`=0, `sel`=1 (B treated as last served, so A wins the first tie). Resulting `uo_out` = 8'h08; `uio_out` = `uio_oe` = 0.
- **IDLE:**
  - `req_a` & `req_b` → grant the requester other than `sel`.
  - Only one request asserted → grant that requester.
  - No request → stay in IDLE.
- **Grant entry:** load `cnt` ← `quantum`, and set `sel` to the granted side (A → 0, B → 1).
- **In GNT_X, evaluated each cycle, first match wins:**
  1. `req_X`=0 → release. Grant the other side if it is requesting, else go to IDLE.
  2. `cnt`≠0 → decrement `cnt`.
  3. `cnt`=0 and `lock`=1 → hold the grant; `cnt` stays at 0.
  4. `cnt`=0, `lock`=0, other side requesting → switch directly to the other side, with no idle cycle, and reload `cnt`.
  5. `cnt`=0, `lock`=0, other side idle → renew GNT_X and reload `cnt`.
- **Quantum length:** a grant lasts `quantum`+1 cycles while `lock`=0. `quantum` is sampled only at grant entry or renewal; changing it mid-grant has no effect on the current grant.
- **Mux output:** `y` = (`gnt_a` & `data_a`) | (`gnt_b` & `data_b`). This is combinational from the registered grants and live data, so `y`=0 in IDLE.
- **Expire flag:** `expire` = (`gnt_a` | `gnt_b`) & (`cnt`==0).
- **Mid-operation reset:** asserting `rst_n` low clears all outputs to their reset values immediately, without waiting for a clock edge.

## Timing
- Request to grant: 1 cycle. A request sampled high at edge n gives a grant visible after edge n; there is no combinational path from `req` to `gnt`.
- Release: `req_X` sampled low at edge n → `gnt_X`=0 after edge n. If the other side is requesting, its grant is asserted in the same cycle.
- Switch on expiry: the last owner cycle has `cnt`=0; the new owner's grant appears on the next cycle. Grants are never both high and there is no dead cycle.
- `y` follows `data_*` combinationally during a grant (zero latency).
- Simultaneous `req_X` drop and expiry: release rule 1 takes priority.
- `lock` takes effect only when `cnt`=0; asserting it earlier does not freeze `cnt`.

## Test plan
- **Reset:** `rst_n`=0 with arbitrary `ui_in` → `uo_out`=8'h08, `uio_out`=`uio_oe`=0. Drop `rst_n` mid-grant → outputs return to 8'h08 before the next edge.
- **Single requester:** `quantum`=2, `req_a` held for 8 cycles → `gnt_a` asserted 1 cycle after the request, `cnt` sequence 2,1,0,2,1,0,…; `y` tracks `data_a`; `gnt_b`=0 throughout.
- **Contention:** `quantum`=3, `req_a`=`req_b`=1 from reset → A granted for 4 cycles, then B for 4, then A again. No gap between grants and never both grants high.
- **Early release:** B granted with `cnt`=5 while `req_a`=1; drop `req_b` → next cycle `gnt_a`=1 and `cnt`=`quantum`.
- **Lock:** `quantum`=0, both requesting, `lock`=1 → owner keeps the grant with `cnt`=0 and `expire`=1 for 10 cycles. Drop `lock` → switch to the other side on the next cycle.
- **Quantum change mid-grant:** A granted with `quantum`=7; set `quantum`=1 after 2 cycles → the A grant still lasts 8 cycles in total, and the next grant uses length 2.
